// File: rtl/noise_lfsr_multi.sv
// rtl/noise_lfsr_multi.sv - PSG noise source: period prescaler plus right-shift LFSR
// with white/periodic modes, clock-enabled, synchronous reset and restart.
module noise_lfsr_multi #(
  parameter int COUNTER_BITS = 5,
  parameter int LFSR_BITS    = 17,
  parameter int LFSR_TAP0    = 0,
  parameter int LFSR_TAP1    = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic [COUNTER_BITS-1:0] period,
  input  logic                    mode,
  input  logic                    restart,
  output logic                    out,
  output logic                    shift_strobe,
  output logic [LFSR_BITS-1:0]    lfsr_state
);

  localparam logic [COUNTER_BITS-1:0] CNT_ONE = {{(COUNTER_BITS-1){1'b0}}, 1'b1};

  logic [COUNTER_BITS-1:0] cnt;
  logic [COUNTER_BITS-1:0] p_eff;
  logic                    phase;
  logic                    wrap;
  logic                    do_shift;
  logic                    zero;
  logic                    fb;
  logic [LFSR_BITS-1:0]    lfsr_next;

  // >= rather than == so a period lowered below cnt mid-count wraps immediately
  assign p_eff    = (period == '0) ? CNT_ONE : period;
  assign wrap     = (cnt >= (p_eff - CNT_ONE));
  assign do_shift = en & wrap & ~phase;

  // Injecting a 1 when the register is all-zero lets both modes leave the lock-up state
  assign zero      = (lfsr_state == '0);
  assign fb        = mode ? (lfsr_state[0] | zero)
                          : ((lfsr_state[LFSR_TAP0] ^ lfsr_state[LFSR_TAP1]) | zero);
  assign lfsr_next = {fb, lfsr_state[LFSR_BITS-1:1]};

  always_ff @(posedge clk) begin
    if (reset || restart) begin
      cnt          <= '0;
      phase        <= 1'b0;
      lfsr_state   <= '0;
      shift_strobe <= 1'b0;
      out          <= 1'b1;
    end else begin
      shift_strobe <= do_shift;
      if (en) begin
        if (wrap) begin
          cnt   <= '0;
          phase <= ~phase;
        end else begin
          cnt <= cnt + CNT_ONE;
        end
      end
      if (do_shift) begin
        lfsr_state <= lfsr_next;
        out        <= ~lfsr_next[0];
      end
    end
  end

endmodule

// File: tb/tb_noise_lfsr_multi.sv
// tb/tb_noise_lfsr_multi.sv - scoreboard bench for noise_lfsr_multi
// (reference model queued per clock, compared after each edge).
module tb_noise_lfsr_multi;

  logic        clk = 1'b0;
  logic        reset, en, mode, restart;
  logic [4:0]  period;
  logic        out, shift_strobe;
  logic [16:0] lfsr_state;

  noise_lfsr_multi dut (
    .clk(clk), .reset(reset), .en(en), .period(period), .mode(mode),
    .restart(restart), .out(out), .shift_strobe(shift_strobe), .lfsr_state(lfsr_state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        stb;
    logic [16:0] lfsr;
    logic        o;
  } exp_t;

  exp_t sb[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_stb = 0;
  int gap = 0;
  int nstb = 0;
  bit duty3 = 1'b0;

  // reference model state
  int          m_cnt = 0;
  bit          m_ph = 1'b0;
  logic [16:0] m_lfsr = '0;
  bit          m_stb = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    exp_t e;
    int   p;
    logic fbm;
    if (duty3) en = (cyc % 3 == 0);
    p = (period == 0) ? 1 : int'(period);
    if (reset || restart) begin
      m_cnt = 0; m_ph = 1'b0; m_lfsr = '0; m_stb = 1'b0;
    end else if (en) begin
      m_stb = 1'b0;
      if (m_cnt >= p - 1) begin
        m_cnt = 0;
        if (!m_ph) begin
          if (m_lfsr == 0) fbm = 1'b1;
          else if (mode) fbm = m_lfsr[0];
          else fbm = m_lfsr[0] ^ m_lfsr[3];
          m_lfsr = {fbm, m_lfsr[16:1]};
          m_stb  = 1'b1;
        end
        m_ph = !m_ph;
      end else begin
        m_cnt++;
      end
    end else begin
      m_stb = 1'b0;
    end
    e.stb = m_stb; e.lfsr = m_lfsr; e.o = ~m_lfsr[0];
    sb.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    e = sb.pop_front();
    check("strobe", 32'(shift_strobe), 32'(e.stb));
    check("lfsr", 32'(lfsr_state), 32'(e.lfsr));
    check("out", 32'(out), 32'(e.o));
    if (shift_strobe) begin
      gap = cyc - last_stb;
      last_stb = cyc;
      nstb++;
    end
  endtask

  task automatic wait_strobe(input int limit);
    int start;
    start = nstb;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (nstb != start) break;
    end
    if (nstb == start) check("strobe_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_restart();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    last_stb = cyc;
  endtask

  int zeros;
  int c0;

  initial begin
    reset = 1'b1; en = 1'b0; period = 5'd1; mode = 1'b0; restart = 1'b0;
    tick(); tick();
    check("reset_lfsr", 32'(lfsr_state), 32'h0);
    check("reset_out", 32'(out), 32'h1);
    check("reset_strobe", 32'(shift_strobe), 32'h0);

    // white mode, period 1
    reset = 1'b0; en = 1'b1;
    last_stb = cyc;
    wait_strobe(10);
    check("first_shift_lfsr", 32'(lfsr_state), 32'h10000);
    check("first_shift_out", 32'(out), 32'h1);
    wait_strobe(10);
    check("p1_gap", 32'(gap), 32'd2);
    check("second_shift_lfsr", 32'(lfsr_state), 32'h08000);
    for (int i = 0; i < 215; i++) wait_strobe(10);
    check("p1_gap_late", 32'(gap), 32'd2);

    // period 0 behaves like 1
    period = 5'd0;
    do_restart();
    wait_strobe(10);
    check("p0_first", 32'(gap), 32'd1);
    check("p0_first_lfsr", 32'(lfsr_state), 32'h10000);
    wait_strobe(10);
    check("p0_gap", 32'(gap), 32'd2);

    // period 31
    period = 5'd31;
    do_restart();
    wait_strobe(100);
    check("p31_first", 32'(gap), 32'd31);
    wait_strobe(100);
    check("p31_gap", 32'(gap), 32'd62);

    // 1/3 duty enable
    duty3 = 1'b1;
    wait_strobe(400);
    wait_strobe(400);
    check("duty3_gap", 32'(gap), 32'd186);
    duty3 = 1'b0; en = 1'b1;

    // periodic mode: a single one circulates
    mode = 1'b1; period = 5'd1;
    do_restart();
    zeros = 0;
    for (int i = 0; i < 34; i++) begin
      wait_strobe(10);
      if (!out) zeros++;
    end
    check("periodic_zeros", 32'(zeros), 32'd2);
    check("periodic_ones", 32'($countones(lfsr_state)), 32'd1);
    mode = 1'b0;
    for (int i = 0; i < 30; i++) wait_strobe(10);

    // restart together with en
    period = 5'd4;
    for (int i = 0; i < 5; i++) wait_strobe(20);
    do_restart();
    check("restart_lfsr", 32'(lfsr_state), 32'h0);
    check("restart_out", 32'(out), 32'h1);
    check("restart_strobe", 32'(shift_strobe), 32'h0);
    wait_strobe(20);
    check("restart_first", 32'(gap), 32'd4);
    check("restart_first_lfsr", 32'(lfsr_state), 32'h10000);

    // period lowered below cnt mid-count
    period = 5'd20;
    do_restart();
    for (int i = 0; i < 10; i++) tick();
    period = 5'd3;
    c0 = cyc;
    wait_strobe(10);
    check("lowered_wrap", 32'(cyc - c0), 32'd1);
    wait_strobe(20);
    check("lowered_gap", 32'(gap), 32'd6);

    // reset mid-count
    tick(); tick();
    reset = 1'b1;
    tick();
    check("midreset_lfsr", 32'(lfsr_state), 32'h0);
    check("midreset_out", 32'(out), 32'h1);
    check("midreset_strobe", 32'(shift_strobe), 32'h0);
    reset = 1'b0;
    last_stb = cyc;
    wait_strobe(10);
    check("post_reset_first", 32'(gap), 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
